// File: rtl/prog_loader_if.sv
// ============================================================================
//  prog_loader_if
//  Byte-stream, program-memory write and CPU-control signals of the loader.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface prog_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        skip;
    logic        clear;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [1:0]  error_code;

    modport master (
        output in_valid, in_data, skip, clear,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, done, error, error_code
    );

    modport slave (
        input  in_valid, in_data, skip, clear,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, done, error, error_code
    );
endinterface

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
//  prog_loader
//  Receives a framed, checksummed byte stream and writes it to program memory.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module prog_loader (
    input  logic          clk,
    input  logic          rst_n,
    prog_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [7:0] C_SYNC_BYTE = 8'hA5;
    localparam logic [1:0] C_ERR_NONE  = 2'b00;
    localparam logic [1:0] C_ERR_LEN   = 2'b01;
    localparam logic [1:0] C_ERR_CHK   = 2'b10;

    state_t      state_q, state_d;
    logic [3:0]  len_hi_q, len_hi_d;
    logic [11:0] len_q, len_d;
    logic [11:0] cnt_q, cnt_d;
    logic [7:0]  sum_q, sum_d;
    logic        mem_we_q, mem_we_d;
    logic [11:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [1:0]  code_q, code_d;

    logic        w_ready;
    logic        w_xfer;
    logic [11:0] w_len;

    assign w_ready = (state_q != ST_RUN) && (state_q != ST_ERROR);
    assign w_xfer  = bus.in_valid && w_ready;
    assign w_len   = {len_hi_q, bus.in_data};

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = done_q;
        error_d     = error_q;
        code_d      = code_q;

        // clear outranks any byte arriving in the same cycle
        if (bus.clear) begin
            state_d = ST_SYNC;
            cnt_d   = 12'd0;
            sum_d   = 8'd0;
            done_d  = 1'b0;
            error_d = 1'b0;
            code_d  = C_ERR_NONE;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (bus.skip) begin
                        state_d = ST_RUN;
                        done_d  = 1'b0;
                    end else if (w_xfer && bus.in_data == C_SYNC_BYTE) begin
                        state_d = ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_xfer) begin
                        if (bus.in_data[7:4] != 4'd0) begin
                            state_d = ST_ERROR;
                            error_d = 1'b1;
                            code_d  = C_ERR_LEN;
                        end else begin
                            len_hi_d = bus.in_data[3:0];
                            state_d  = ST_LEN_LO;
                        end
                    end
                end
                ST_LEN_LO: begin
                    // an odd length also excludes 4095, capping LEN at 4094
                    if (w_xfer) begin
                        if (w_len == 12'd0 || w_len[0]) begin
                            state_d = ST_ERROR;
                            error_d = 1'b1;
                            code_d  = C_ERR_LEN;
                        end else begin
                            len_d   = w_len;
                            cnt_d   = 12'd0;
                            sum_d   = 8'd0;
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cnt_q;
                        mem_wdata_d = bus.in_data;
                        sum_d       = sum_q + bus.in_data;
                        cnt_d       = cnt_q + 12'd1;
                        if (cnt_q == len_q - 12'd1) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_xfer) begin
                        if (bus.in_data == sum_q) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_ERROR;
                            error_d = 1'b1;
                            code_d  = C_ERR_CHK;
                        end
                    end
                end
                ST_RUN:   state_d = ST_RUN;
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SYNC;
            len_hi_q    <= 4'd0;
            len_q       <= 12'd0;
            cnt_q       <= 12'd0;
            sum_q       <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 12'd0;
            mem_wdata_q <= 8'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            code_q      <= C_ERR_NONE;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
            code_q      <= code_d;
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_hold   = (state_q != ST_RUN);
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.error_code = code_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
//  tb_prog_loader
//  Directed self-checking bench for the frame loader.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_prog_loader;

    logic clk;
    logic rst_n;
    prog_loader_if bus ();

    prog_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [19:0] log_q[$];

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) log_q.push_back({bus.mem_addr, bus.mem_wdata});
    end

    task automatic push(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        bus.in_valid = 1'b0;
        bus.clear    = 1'b1;
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
    endtask

    task automatic send_good();
        push(8'hA5); push(8'h00); push(8'h04);
        push(8'h12); push(8'h34); push(8'h56); push(8'h78);
        push(8'h14);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({bus.in_ready, bus.mem_we, bus.cpu_hold, bus.done, bus.error, bus.error_code} !== 7'b1010000) begin
            bad++;
            $display("FAIL reset_ctrl: got rdy/we/hold/done/err/code=%b expected 1010000",
                     {bus.in_ready, bus.mem_we, bus.cpu_hold, bus.done, bus.error, bus.error_code});
        end
        total++;
        if (bus.mem_addr !== 12'h000 || bus.mem_wdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_bus: got addr=%h data=%h expected 000/00", bus.mem_addr, bus.mem_wdata);
        end
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame();
        logic [7:0] d [4];
        d = '{8'h12, 8'h34, 8'h56, 8'h78};
        push(8'hA5); push(8'h00); push(8'h04);
        total++;
        if (bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL good_hdr_we: got %b expected 0", bus.mem_we);
        end
        for (int i = 0; i < 4; i++) begin
            push(d[i]);
            total++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 12'(i) || bus.mem_wdata !== d[i]) begin
                bad++;
                $display("FAIL good_wr%0d: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                         i, bus.mem_we, bus.mem_addr, bus.mem_wdata, 12'(i), d[i]);
            end
        end
        total++;
        if (bus.cpu_hold !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL good_pre_chk: got hold=%b done=%b expected 1/0", bus.cpu_hold, bus.done);
        end
        push(8'h14);
        bus.in_valid = 1'b0;
        total++;
        if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.error !== 1'b0 || bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL good_done: got done=%b hold=%b rdy=%b err=%b we=%b expected 1/0/0/0/0",
                     bus.done, bus.cpu_hold, bus.in_ready, bus.error, bus.mem_we);
        end
    endtask

    task automatic test_sync_stalls();
        logic [7:0] s [11];
        logic [7:0] d [4];
        int n0;
        s = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
        d = '{8'h12, 8'h34, 8'h56, 8'h78};
        do_clear();
        n0 = log_q.size();
        for (int i = 0; i < 11; i++) begin
            push(s[i]);
            idle();
        end
        total++;
        if (log_q.size() != n0 + 4) begin
            bad++;
            $display("FAIL stall_wr_count: got %0d expected 4", log_q.size() - n0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (log_q[n0 + k] !== {12'(k), d[k]}) begin
                    bad++;
                    $display("FAIL stall_wr%0d: got %h expected %h", k, log_q[n0 + k], {12'(k), d[k]});
                end
            end
        end
        total++;
        if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL stall_done: got done=%b hold=%b expected 1/0", bus.done, bus.cpu_hold);
        end
    endtask

    task automatic test_bad_length();
        int n0;
        do_clear();
        total++;
        if (bus.done !== 1'b0 || bus.cpu_hold !== 1'b1 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_state: got done=%b hold=%b rdy=%b expected 0/1/1", bus.done, bus.cpu_hold, bus.in_ready);
        end
        n0 = log_q.size();
        push(8'hA5); push(8'h00); push(8'h03);
        bus.in_valid = 1'b0;
        idle();
        total++;
        if (bus.error !== 1'b1 || bus.error_code !== 2'b01 || bus.in_ready !== 1'b0 ||
            bus.cpu_hold !== 1'b1 || log_q.size() != n0) begin
            bad++;
            $display("FAIL len_odd: got err=%b code=%b rdy=%b hold=%b writes=%0d expected 1/01/0/1/0",
                     bus.error, bus.error_code, bus.in_ready, bus.cpu_hold, log_q.size() - n0);
        end
        do_clear();
        total++;
        if (bus.error !== 1'b0 || bus.error_code !== 2'b00) begin
            bad++;
            $display("FAIL clear_err: got err=%b code=%b expected 0/00", bus.error, bus.error_code);
        end
        push(8'hA5); push(8'h10);
        total++;
        if (bus.error !== 1'b1 || bus.error_code !== 2'b01 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL len_hi: got err=%b code=%b rdy=%b expected 1/01/0", bus.error, bus.error_code, bus.in_ready);
        end
        push(8'h02);
        do_clear();
        push(8'hA5); push(8'h00); push(8'h00);
        bus.in_valid = 1'b0;
        total++;
        if (bus.error !== 1'b1 || bus.error_code !== 2'b01) begin
            bad++;
            $display("FAIL len_zero: got err=%b code=%b expected 1/01", bus.error, bus.error_code);
        end
    endtask

    task automatic test_checksum();
        int n0;
        do_clear();
        n0 = log_q.size();
        push(8'hA5); push(8'h00); push(8'h02); push(8'hAB); push(8'hCD); push(8'h00);
        bus.in_valid = 1'b0;
        idle();
        total++;
        if (log_q.size() != n0 + 2 || log_q[n0] !== 20'h000AB || log_q[n0 + 1] !== 20'h001CD) begin
            bad++;
            $display("FAIL chk_writes: got count=%0d first=%h second=%h expected 2/000AB/001CD",
                     log_q.size() - n0, log_q[n0], log_q[n0 + 1]);
        end
        total++;
        if (bus.error !== 1'b1 || bus.error_code !== 2'b10 || bus.cpu_hold !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL chk_err: got err=%b code=%b hold=%b done=%b expected 1/10/1/0",
                     bus.error, bus.error_code, bus.cpu_hold, bus.done);
        end
        do_clear();
        send_good();
        total++;
        if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL chk_recover: got done=%b err=%b hold=%b expected 1/0/0", bus.done, bus.error, bus.cpu_hold);
        end
    endtask

    task automatic test_skip_clear();
        int n0;
        do_clear();
        n0 = log_q.size();
        bus.skip = 1'b1;
        @(posedge clk);
        #1;
        bus.skip = 1'b0;
        total++;
        if (bus.cpu_hold !== 1'b0 || bus.done !== 1'b0 || bus.in_ready !== 1'b0 || log_q.size() != n0) begin
            bad++;
            $display("FAIL skip: got hold=%b done=%b rdy=%b writes=%0d expected 0/0/0/0",
                     bus.cpu_hold, bus.done, bus.in_ready, log_q.size() - n0);
        end
        do_clear();
        bus.skip = 1'b1;
        push(8'hA5);
        bus.skip = 1'b0;
        bus.in_valid = 1'b0;
        total++;
        if (bus.cpu_hold !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL skip_xfer: got hold=%b rdy=%b expected 0/0", bus.cpu_hold, bus.in_ready);
        end
        do_clear();
        n0 = log_q.size();
        push(8'hA5); push(8'h00); push(8'h04); push(8'h12);
        bus.clear = 1'b1;
        push(8'h34);
        bus.clear = 1'b0;
        total++;
        if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL clear_data: got we=%b rdy=%b hold=%b done=%b expected 0/1/1/0",
                     bus.mem_we, bus.in_ready, bus.cpu_hold, bus.done);
        end
        push(8'h56); push(8'h78);
        bus.in_valid = 1'b0;
        idle();
        total++;
        if (log_q.size() != n0 + 1) begin
            bad++;
            $display("FAIL clear_writes: got %0d expected 1", log_q.size() - n0);
        end
    endtask

    task automatic test_async_reset();
        int n0;
        do_clear();
        push(8'hA5); push(8'h00); push(8'h04); push(8'h12); push(8'h34);
        bus.in_valid = 1'b0;
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 12'h001) begin
            bad++;
            $display("FAIL arst_pre: got we=%b addr=%h expected 1/001", bus.mem_we, bus.mem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.in_ready, bus.mem_we, bus.cpu_hold, bus.done, bus.error, bus.error_code} !== 7'b1010000 ||
            bus.mem_addr !== 12'h000 || bus.mem_wdata !== 8'h00) begin
            bad++;
            $display("FAIL arst_now: got rdy/we/hold/done/err/code=%b addr=%h data=%h expected 1010000/000/00",
                     {bus.in_ready, bus.mem_we, bus.cpu_hold, bus.done, bus.error, bus.error_code},
                     bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n0 = log_q.size();
        send_good();
        total++;
        if (log_q.size() != n0 + 4 || log_q[n0] !== 20'h00012 || bus.done !== 1'b1) begin
            bad++;
            $display("FAIL arst_reload: got count=%0d first=%h done=%b expected 4/00012/1",
                     log_q.size() - n0, log_q[n0], bus.done);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.skip     = 1'b0;
        bus.clear    = 1'b0;
        test_reset();
        test_good_frame();
        test_sync_stalls();
        test_bad_length();
        test_checksum();
        test_skip_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
